mem_port_arbiter: RTL and testbench

Parametrised memory-port controller for the multi-cycle datapath generation. It arbitrates NUM_CH requesters (ch0 = instruction fetch, ch1 = load/store, further channels for DMA/debug) onto the single readM/writeM/inputReady/ackOutput memory handshake. Each access runs through a full four-phase handshake, is bounded by a timeout, and returns a per-channel response. The block replaces the inline wait-based memory sequencing inside the datapath.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_rr.sv | 35 +++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encoding, default width
// and the channel-index width helper.
package mem_port_arbiter_pkg;

  localparam int DEFAULT_WORD_SIZE = 16;
  localparam int CNT_W             = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RD_REL = 3'd2,
    ST_WR     = 3'd3,
    ST_WR_REL = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Combinational requester selection: round-robin from a pointer, or fixed
// priority with the lowest index winning.
module rr_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter  int NUM_CH    = 2,
  parameter  int PRIO_MODE = 0,
  localparam int IW        = ch_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] valid_i,
  input  logic [IW-1:0]     ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IW-1:0]     idx_o
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (PRIO_MODE == 1) cand = IW'(k);
      else                cand = IW'((int'(ptr_i) + k) % NUM_CH);
      if (!found && valid_i[cand]) begin
        found        = 1'b1;
        idx_o        = cand;
        gnt_o[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates NUM_CH requesters onto one four-phase readM/writeM memory
// handshake, with a per-edge timeout and a one-cycle per-channel response.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int NUM_CH    = 2,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           req_valid,
  input  logic [NUM_CH-1:0]           req_write,
  input  logic [NUM_CH*WORD_SIZE-1:0] req_addr,
  input  logic [NUM_CH*WORD_SIZE-1:0] req_wdata,
  output logic [NUM_CH-1:0]           req_ready,
  output logic [NUM_CH-1:0]           resp_valid,
  output logic [WORD_SIZE-1:0]        resp_rdata,
  output logic                        resp_err,
  output logic                        readM,
  output logic                        writeM,
  output logic [WORD_SIZE-1:0]        address,
  inout  logic [WORD_SIZE-1:0]        data,
  input  logic                        inputReady,
  input  logic                        ackOutput
);

  localparam int IW = ch_idx_w(NUM_CH);

  state_e                state_q, state_d;
  logic [IW-1:0]         ptr_q, gidx_q, arb_idx, next_ptr;
  logic [NUM_CH-1:0]     arb_gnt, resp_valid_q;
  logic [WORD_SIZE-1:0]  addr_q, wdata_q, rdata_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  readM_q, writeM_q, drive_q, err_q;
  logic                  any_req, waiting, expired, abort;

  rr_arbiter #(
    .NUM_CH    (NUM_CH),
    .PRIO_MODE (PRIO_MODE)
  ) u_arb (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx)
  );

  assign any_req  = |req_valid;
  assign next_ptr = (int'(arb_idx) == NUM_CH - 1) ? '0 : arb_idx + 1'b1;
  assign waiting  = (state_q == ST_RD) || (state_q == ST_RD_REL) ||
                    (state_q == ST_WR) || (state_q == ST_WR_REL);
  assign expired  = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Abort only when the edge being waited for has still not arrived.
  assign abort = expired &&
                 (((state_q == ST_RD)     && !inputReady) ||
                  ((state_q == ST_RD_REL) &&  inputReady) ||
                  ((state_q == ST_WR)     && !ackOutput)  ||
                  ((state_q == ST_WR_REL) &&  ackOutput));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (any_req) state_d = req_write[arb_idx] ? ST_WR : ST_RD;
      ST_RD:     if (inputReady) state_d = ST_RD_REL;
                 else if (abort) state_d = ST_RESP;
      ST_RD_REL: if (!inputReady || abort) state_d = ST_RESP;
      ST_WR:     if (ackOutput) state_d = ST_WR_REL;
                 else if (abort) state_d = ST_RESP;
      ST_WR_REL: if (!ackOutput || abort) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      gidx_q       <= '0;
      addr_q       <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
      readM_q      <= 1'b0;
      writeM_q     <= 1'b0;
      drive_q      <= 1'b0;
      err_q        <= 1'b0;
      resp_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= '0;
      // Bus stays driven for the cycle after writeM falls to give hold time.
      drive_q      <= (state_d == ST_WR) || (state_q == ST_WR);
      if (state_d != state_q) cnt_q <= '0;
      else if (waiting)       cnt_q <= cnt_q + 1'b1;
      case (state_q)
        ST_IDLE: if (any_req) begin
          addr_q   <= req_addr[arb_idx*WORD_SIZE +: WORD_SIZE];
          gidx_q   <= arb_idx;
          ptr_q    <= next_ptr;
          readM_q  <= !req_write[arb_idx];
          writeM_q <=  req_write[arb_idx];
        end
        ST_RD: begin
          if (inputReady) rdata_q <= data;
          if (inputReady || abort) readM_q <= 1'b0;
        end
        ST_WR: if (ackOutput || abort) writeM_q <= 1'b0;
        default: ;
      endcase
      if (abort) rdata_q <= '0;
      if (state_d == ST_RESP) begin
        resp_valid_q <= NUM_CH'(1) << gidx_q;
        err_q        <= abort;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && any_req)
      wdata_q <= req_wdata[arb_idx*WORD_SIZE +: WORD_SIZE];
  end

  assign req_ready  = (state_q == ST_IDLE && !reset) ? arb_gnt : '0;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign readM      = readM_q;
  assign writeM     = writeM_q;
  assign address    = addr_q;
  assign data       = drive_q ? wdata_q : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one round-robin instance with a short
// timeout and one fixed-priority instance used for the contention case.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  req_valid, req_write, req_ready, resp_valid;
  logic [31:0] req_addr, req_wdata;
  logic [15:0] resp_rdata, address;
  logic        resp_err, readM, writeM, inputReady, ackOutput;
  wire  [15:0] data_bus;
  logic        mem_oe;
  logic [15:0] mem_drv;
  assign data_bus = mem_oe ? mem_drv : 16'bz;

  logic [1:0]  f_req_valid, f_req_ready, f_resp_valid;
  logic [15:0] f_resp_rdata, f_address;
  logic        f_resp_err, f_readM, f_writeM;
  wire  [15:0] f_data;
  assign f_data = f_readM ? 16'h0000 : 16'bz;

  int vecs = 0;
  int errs = 0;

  mem_port_arbiter #(.WORD_SIZE(16), .NUM_CH(2), .PRIO_MODE(0), .TIMEOUT(8)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .readM(readM), .writeM(writeM), .address(address), .data(data_bus),
    .inputReady(inputReady), .ackOutput(ackOutput)
  );

  mem_port_arbiter #(.WORD_SIZE(16), .NUM_CH(2), .PRIO_MODE(1), .TIMEOUT(2)) u_fp (
    .clk(clk), .reset(reset), .req_valid(f_req_valid), .req_write(2'b00),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(f_req_ready),
    .resp_valid(f_resp_valid), .resp_rdata(f_resp_rdata), .resp_err(f_resp_err),
    .readM(f_readM), .writeM(f_writeM), .address(f_address), .data(f_data),
    .inputReady(1'b0), .ackOutput(1'b0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int mcnt, fcnt;
    logic [1:0] mseq [4];
    logic [1:0] fseq [4];

    reset = 1'b1; req_valid = 2'b11; req_write = 2'b00;
    req_addr = '0; req_wdata = '0; inputReady = 1'b0; ackOutput = 1'b0;
    mem_oe = 1'b0; mem_drv = '0; f_req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin mseq[i] = 2'b00; fseq[i] = 2'b00; end
    #12;
    chk("rst_readM", readM, 0);
    chk("rst_writeM", writeM, 0);
    chk("rst_address", address, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    reset = 1'b0; req_valid = 2'b00;

    // Single read, data after two cycles; a stray ackOutput must be ignored
    tick();
    req_valid = 2'b01; req_write = 2'b00; req_addr = {16'h0000, 16'h0010};
    #1 chk("rd_req_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00; ackOutput = 1'b1;
    #1 chk("rd_readM_c0", readM, 1); chk("rd_address", address, 16'h0010);
    tick(); ackOutput = 1'b0;
    #1 chk("rd_readM_c1", readM, 1);
    tick(); inputReady = 1'b1; mem_oe = 1'b1; mem_drv = 16'hBEEF;
    #1 chk("rd_readM_c2", readM, 1);
    tick(); inputReady = 1'b0; mem_oe = 1'b0;
    #1 chk("rd_readM_fall", readM, 0); chk("rd_no_early_resp", resp_valid, 0);
    tick();
    #1 chk("rd_resp_valid", resp_valid, 2'b01);
    chk("rd_rdata", resp_rdata, 16'hBEEF); chk("rd_err", resp_err, 0);
    tick();
    #1 chk("rd_resp_pulse", resp_valid, 0);

    // Single write on ch1
    mem_oe = 1'b1; mem_drv = 16'hA5A5;
    #1 chk("idle_bus_hiz", data_bus, 16'hA5A5);
    mem_oe = 1'b0;
    req_valid = 2'b10; req_write = 2'b10;
    req_addr = {16'h0020, 16'h0000}; req_wdata = {16'h1234, 16'h0000};
    #1 chk("wr_req_ready", req_ready, 2'b10);
    tick(); req_valid = 2'b00;
    #1 chk("wr_writeM", writeM, 1); chk("wr_readM", readM, 0);
    chk("wr_address", address, 16'h0020); chk("wr_data", data_bus, 16'h1234);
    tick(); ackOutput = 1'b1;
    #1 chk("wr_writeM_hold", writeM, 1);
    tick(); ackOutput = 1'b0;
    #1 chk("wr_writeM_fall", writeM, 0); chk("wr_data_hold", data_bus, 16'h1234);
    tick(); mem_oe = 1'b1; mem_drv = 16'hA5A5;
    #1 chk("wr_bus_hiz", data_bus, 16'hA5A5);
    chk("wr_resp_valid", resp_valid, 2'b10); chk("wr_err", resp_err, 0);
    chk("wr_rdata_kept", resp_rdata, 16'hBEEF);
    mem_oe = 1'b0;
    tick();
    #1 chk("wr_resp_pulse", resp_valid, 0);

    // Timeout on a read that never completes
    req_valid = 2'b01; req_write = 2'b00; req_addr = {16'h0000, 16'h0030};
    tick(); req_valid = 2'b00;
    #1;
    n = 0;
    while (readM === 1'b1 && n < 20) begin
      n++;
      tick();
      #1;
    end
    chk("to_readM_cycles", n, 8);
    chk("to_resp_valid", resp_valid, 2'b01);
    chk("to_err", resp_err, 1);
    chk("to_rdata", resp_rdata, 0);
    tick();
    #1 chk("to_resp_pulse", resp_valid, 0);

    // Slow release: data changes while inputReady stays high
    req_valid = 2'b10; req_write = 2'b00; req_addr = {16'h0040, 16'h0000};
    #1 chk("sr_req_ready", req_ready, 2'b10);
    tick(); req_valid = 2'b00; inputReady = 1'b1; mem_oe = 1'b1; mem_drv = 16'hCAFE;
    tick(); mem_drv = 16'h0BAD;
    #1 chk("sr_readM_fall", readM, 0); chk("sr_wait0", resp_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1 chk("sr_wait", resp_valid, 0);
    end
    inputReady = 1'b0; mem_oe = 1'b0;
    tick();
    #1 chk("sr_resp_valid", resp_valid, 2'b10);
    chk("sr_rdata", resp_rdata, 16'hCAFE); chk("sr_err", resp_err, 0);
    tick();

    // Reset in the middle of a write
    req_valid = 2'b01; req_write = 2'b01;
    req_addr = {16'h0000, 16'h0050}; req_wdata = {16'h0000, 16'h5555};
    tick(); req_valid = 2'b11;
    #1 chk("rw_writeM", writeM, 1); chk("rw_data", data_bus, 16'h5555);
    #1 reset = 1'b1;
    #1 chk("rw_writeM_rst", writeM, 0); chk("rw_readM_rst", readM, 0);
    chk("rw_req_ready_rst", req_ready, 0);
    mem_oe = 1'b1; mem_drv = 16'hA5A5;
    #1 chk("rw_bus_hiz", data_bus, 16'hA5A5);
    mem_oe = 1'b0;
    tick(); tick();
    #1 chk("rw_no_resp", resp_valid, 0);
    reset = 1'b0; req_valid = 2'b00;

    // Contention: round-robin alternates, fixed priority always picks ch0
    tick();
    req_write = 2'b00; req_addr = {16'h0070, 16'h0060};
    req_valid = 2'b11; f_req_valid = 2'b11;
    #1 chk("ct_rr_ready", req_ready, 2'b01); chk("ct_fp_ready", f_req_ready, 2'b01);
    mcnt = 0; fcnt = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      #1;
      if (resp_valid != 2'b00 && mcnt < 4) begin mseq[mcnt] = resp_valid; mcnt++; end
      if (f_resp_valid != 2'b00 && fcnt < 4) begin fseq[fcnt] = f_resp_valid; fcnt++; end
    end
    chk("ct_rr_count", mcnt, 4);
    chk("ct_rr_g0", mseq[0], 2'b01); chk("ct_rr_g1", mseq[1], 2'b10);
    chk("ct_rr_g2", mseq[2], 2'b01); chk("ct_rr_g3", mseq[3], 2'b10);
    chk("ct_fp_count", fcnt, 4);
    for (int i = 0; i < 4; i++) chk("ct_fp_g", fseq[i], 2'b01);
    chk("ct_fp_address", f_address, 16'h0060);
    chk("ct_fp_err", f_resp_err, 1);
    chk("ct_fp_rdata", f_resp_rdata, 0);
    chk("ct_fp_writeM", f_writeM, 0);
    req_valid = 2'b00; f_req_valid = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
